hf_decompression_canonical: RTL
===============================

# hf_decompression_canonical

Bit-serial canonical Huffman decoder, the parametrised successor to the single-bit dynamic decompressor. Each frame carries its own code table in a self-describing header: per-length code counts, then the symbol list, then a payload symbol count. The block rebuilds the table, decodes one code bit per cycle, and emits fixed-width symbols on a ready/valid stream. It sits between the serial compressed-bitstream source and the symbol consumer. An optional raw bypass path covers disabled operation.

## Interface
Parameters:
- `SYM_W`, 8: decoded symbol width; the table holds at most `2**SYM_W` symbols.
- `MAX_LEN`, 12: longest legal code length, 1..16.
- `LEN_W`, 6: width of the payload symbol-count field.

Ports:
- `CLK` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `EN` in 1: decode enable, sampled only in IDLE.
- `in_bit` in 1: compressed bitstream, MSB-first for all fields.
- `in_valid` in 1: `in_bit` valid.
- `in_ready` out 1: bit accepted on `in_valid & in_ready`.
- `sym_out` out SYM_W: decoded symbol.
- `sym_valid` out 1: `sym_out` valid.
- `sym_ready` in 1: consumer accepts on `sym_valid & sym_ready`.
- `done` out 1: one-cycle pulse when the frame completes.
- `err` out 1: sticky malformed-frame flag.
- `byp_bit` out 1: bypass data (only with `HF_BYPASS_EN`).
- `byp_valid` out 1: bypass valid (only with `HF_BYPASS_EN`).

## Operation
- Define `CNT_W = SYM_W+1`.
- Frame format:
  - `MAX_LEN` counts `cnt[1..MAX_LEN]`, each `CNT_W` bits.
  - `N = sum(cnt)` symbols, each `SYM_W` bits, in canonical order.
  - `P`, `LEN_W` bits.
  - Payload of `P` codes.
- Symbol table is a `2**SYM_W` x `SYM_W` register array. `cnt` is a `MAX_LEN` x `CNT_W` array.
- States and transitions:
  - IDLE: if `EN` = 1, go to HDR_CNT. If `EN` = 0, stall (or bypass, see Configuration).
  - HDR_CNT: shift in counts and accumulate `N` in a `CNT_W+4`-bit sum. After the last count: if `N` = 0 or `N > 2**SYM_W`, go to ERR; otherwise go to HDR_SYM.
  - HDR_SYM: write `N` symbols at index 0..N-1, then go to HDR_LEN.
  - HDR_LEN: shift in `P`. If `P` = 0, go to DONE; otherwise go to DECODE.
  - DECODE: canonical walk (registers below). On a match, go to EMIT. If `L` exceeds `MAX_LEN` without a match, go to ERR.
  - EMIT: hold `sym_valid` until `sym_ready`, then decrement the remaining count. Go to DONE when it reaches 0, else back to DECODE.
  - DONE: pulse `done`, go to IDLE.
  - ERR: `err` = 1, `in_ready` = 0. Exit only by `Reset`.
- DECODE registers: `code`, `first` (MAX_LEN+1 bits), `index` (CNT_W+4 bits), level `L`, reset at each code start to code = first = index = 0, `L` = 1.
- DECODE walk, per accepted bit `b`:
  - `c = code|b`.
  - If `c-first < cnt[L]`: `sym_out <= tab[index+c-first]`.
  - Else: `index += cnt[L]`, `first = (first+cnt[L])<<1`, `code = c<<1`, `L++`.
- `in_ready` = 1 in HDR_CNT, HDR_SYM, HDR_LEN and DECODE; 0 in EMIT, DONE, ERR and in IDLE except during bypass.
- `EN` changes outside IDLE are ignored until the frame ends.
- Reset values: every output 0, state IDLE, table and counts cleared.
- `Reset` mid-frame aborts immediately. No partial symbol is emitted afterwards.

## Timing
- One input bit per cycle at most. No stall cycles in header or DECODE except when `in_valid` = 0.
- `sym_valid` rises in the cycle after the edge that accepts a code's final bit. Latency is 1.
- Back-to-back codes: the symbol is held in EMIT at least one cycle, so peak throughput is 1 symbol per (code length + 1) cycles.
- `done` asserts the cycle after the final `sym_valid & sym_ready` (or after the last bit of `P` when `P` = 0). It lasts exactly 1 cycle.
- `err` asserts the cycle after the offending bit is accepted.

## Configuration
- `HF_BYPASS_EN`, defined:
  - In IDLE with `EN` = 0, `in_ready` = 1.
  - `byp_bit <= in_bit` and `byp_valid <= in_valid` each cycle (1-cycle latency, raw pass-through).
  - `byp_valid` = 0 in all other states.
- Not defined:
  - `byp_bit`/`byp_valid` ports are absent.
  - In IDLE with `EN` = 0, `in_ready` = 0 (input stalls).

## Test plan
- Basic decode:
  - Stimulus: `cnt[1]`=1, `cnt[2]`=1, `cnt[3]`=2, rest 0; symbols 0x41..0x44; `P`=4; payload 0,10,110,111.
  - Response: `sym_out` 0x41, 0x42, 0x43, 0x44 in order, then one `done` pulse, then IDLE.
- Backpressure: same frame, hold `sym_ready`=0 for 5 cycles on the second symbol. Response: `sym_out`=0x42 stable, `in_ready`=0 throughout, no lost or duplicated symbols.
- Bad code:
  - Stimulus: `cnt[1]`=1 only, symbol 0x41, `P`=1, payload of 12 ones.
  - Response: `err`=1 the cycle after the 12th bit, no `sym_valid`, `in_ready` stays 0.
- Bad header: all counts 0. Response: `err`=1 after the last count bit.
- Empty payload: `P`=0. Response: `done` pulse, `sym_valid` never asserted.
- Reset and bypass:
  - Assert `Reset` mid-DECODE. Response: all outputs 0 immediately; the next frame decodes correctly.
  - With `HF_BYPASS_EN` and `EN`=0, drive bits 1,0,1,1. Response: `byp_bit` shows 1,0,1,1 one cycle later.

Source files
------------

// File: rtl/hf_decompression_canonical_if.sv
// hf_decompression_canonical_if: compressed bit input, symbol output, status and optional bypass (HF_BYPASS_EN) signals
interface hf_decompression_canonical_if #(parameter int SYM_W = 8);
    logic             EN;
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] sym_out;
    logic             sym_valid;
    logic             sym_ready;
    logic             done;
    logic             err;
`ifdef HF_BYPASS_EN
    logic             byp_bit;
    logic             byp_valid;
`endif
    modport master (
        output EN, in_bit, in_valid, sym_ready,
        input  in_ready, sym_out, sym_valid, done, err
`ifdef HF_BYPASS_EN
        , input byp_bit, byp_valid
`endif
    );
    modport slave (
        input  EN, in_bit, in_valid, sym_ready,
        output in_ready, sym_out, sym_valid, done, err
`ifdef HF_BYPASS_EN
        , output byp_bit, byp_valid
`endif
    );
endinterface

// File: rtl/hf_decompression_canonical.sv
// hf_decompression_canonical: bit-serial canonical Huffman decoder with an in-band code table header.
// Defining HF_BYPASS_EN adds a raw pass-through of the input bits while idle with EN low.
module hf_decompression_canonical #(
    parameter int SYM_W   = 8,
    parameter int MAX_LEN = 12,
    parameter int LEN_W   = 6
) (
    input logic CLK,
    input logic Reset,
    hf_decompression_canonical_if.slave bus
);
    localparam int CNT_W  = SYM_W + 1;
    localparam int SUM_W  = CNT_W + 4;
    localparam int CODE_W = MAX_LEN + 1;
    localparam int DW     = CODE_W > CNT_W ? CODE_W : CNT_W;
    localparam int SH_W   = LEN_W > CNT_W ? LEN_W : CNT_W;
    localparam int BC_W   = $clog2(SH_W + 1);
    localparam int L_W    = $clog2(MAX_LEN + 2);
    localparam int CI_W   = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {IDLE, HDR_CNT, HDR_SYM, HDR_LEN, DECODE, EMIT, DONE, ERR} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt [MAX_LEN];
    logic [SYM_W-1:0] r_tab [2**SYM_W];
    logic [SH_W-2:0]  r_sh;
    logic [BC_W-1:0]  r_bc;
    logic [SUM_W-1:0] r_idx, r_n, r_index;
    logic [LEN_W-1:0] r_p;
    logic [CODE_W-1:0] r_code, r_first;
    logic [L_W-1:0]   r_l;
    logic [SYM_W-1:0] r_sym;

    logic             w_acc, w_last, w_hit, w_nbad, w_byp_rdy;
    logic [SH_W-1:0]  w_val;
    logic [BC_W-1:0]  w_fw;
    logic [CNT_W-1:0] w_cnt_l;
    logic [CODE_W-1:0] w_c;
    logic [DW-1:0]    w_diff;
    logic [SUM_W-1:0] w_nsum;

`ifdef HF_BYPASS_EN
    logic r_byp_bit, r_byp_valid;
    assign w_byp_rdy     = r_state == IDLE && !bus.EN;
    assign bus.byp_bit   = r_byp_bit;
    assign bus.byp_valid = r_byp_valid;
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_byp_bit   <= 1'b0;
            r_byp_valid <= 1'b0;
        end else begin
            r_byp_bit   <= bus.in_bit;
            r_byp_valid <= w_byp_rdy && bus.in_valid;
        end
    end
`else
    assign w_byp_rdy = 1'b0;
`endif

    assign bus.in_ready  = (r_state inside {HDR_CNT, HDR_SYM, HDR_LEN, DECODE}) || w_byp_rdy;
    assign bus.sym_valid = r_state == EMIT;
    assign bus.done      = r_state == DONE;
    assign bus.err       = r_state == ERR;
    assign bus.sym_out   = r_sym;

    assign w_acc   = bus.in_valid && bus.in_ready;
    assign w_val   = {r_sh, bus.in_bit};
    assign w_fw    = r_state == HDR_CNT ? BC_W'(CNT_W - 1) : r_state == HDR_SYM ? BC_W'(SYM_W - 1) : BC_W'(LEN_W - 1);
    assign w_last  = w_acc && r_bc == w_fw;
    assign w_nsum  = r_n + SUM_W'(w_val[CNT_W-1:0]);
    assign w_nbad  = w_nsum == '0 || w_nsum > SUM_W'(2**SYM_W);
    // Canonical walk: the code is a match at level L when it falls inside that level's block
    assign w_cnt_l = r_cnt[CI_W'(r_l - 1'b1)];
    assign w_c     = r_code | CODE_W'(bus.in_bit);
    assign w_diff  = DW'(w_c) - DW'(r_first);
    assign w_hit   = w_diff < DW'(w_cnt_l);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.EN ? HDR_CNT : IDLE;
            HDR_CNT: if (w_last && r_idx == SUM_W'(MAX_LEN - 1)) w_next = w_nbad ? ERR : HDR_SYM;
            HDR_SYM: if (w_last && r_idx == r_n - 1'b1) w_next = HDR_LEN;
            HDR_LEN: if (w_last) w_next = w_val[LEN_W-1:0] == '0 ? DONE : DECODE;
            DECODE:  if (w_acc) w_next = w_hit ? EMIT : r_l == L_W'(MAX_LEN) ? ERR : DECODE;
            EMIT:    if (bus.sym_ready) w_next = r_p == LEN_W'(1) ? DONE : DECODE;
            DONE:    w_next = IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < MAX_LEN; i++) r_cnt[i] <= '0;
            for (int i = 0; i < 2**SYM_W; i++) r_tab[i] <= '0;
            r_sh    <= '0;
            r_bc    <= '0;
            r_idx   <= '0;
            r_n     <= '0;
            r_index <= '0;
            r_p     <= '0;
            r_code  <= '0;
            r_first <= '0;
            r_l     <= '0;
            r_sym   <= '0;
        end else begin
            if (w_acc) r_sh <= w_val[SH_W-2:0];
            if (w_acc && (r_state inside {HDR_CNT, HDR_SYM, HDR_LEN})) r_bc <= w_last ? '0 : r_bc + 1'b1;
            if (r_state == IDLE) begin
                r_bc  <= '0;
                r_idx <= '0;
                r_n   <= '0;
            end
            if (r_state == HDR_CNT && w_last) begin
                r_cnt[CI_W'(r_idx)] <= w_val[CNT_W-1:0];
                r_n   <= w_nsum;
                r_idx <= r_idx == SUM_W'(MAX_LEN - 1) ? '0 : r_idx + 1'b1;
            end
            if (r_state == HDR_SYM && w_last) begin
                r_tab[SYM_W'(r_idx)] <= w_val[SYM_W-1:0];
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == HDR_LEN && w_last) r_p <= w_val[LEN_W-1:0];
            if (r_state == EMIT && bus.sym_ready) r_p <= r_p - 1'b1;
            if (w_next == DECODE && r_state != DECODE) begin
                r_code  <= '0;
                r_first <= '0;
                r_index <= '0;
                r_l     <= L_W'(1);
            end else if (r_state == DECODE && w_acc && !w_hit) begin
                r_index <= r_index + SUM_W'(w_cnt_l);
                r_first <= (r_first + CODE_W'(w_cnt_l)) << 1;
                r_code  <= w_c << 1;
                r_l     <= r_l + 1'b1;
            end
            if (r_state == DECODE && w_acc && w_hit) r_sym <= r_tab[SYM_W'(r_index + SUM_W'(w_diff))];
        end
    end
endmodule
